// File: rtl/vga_scan_ctrl_pkg.sv
// Shared VGA timing constants, pixel-format field positions and scan-control types.
// The raster counters, the delay line and the page renderers all import this package.
package vga_scan_ctrl_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int CNT_W = 10;
  localparam int PIX_W = 12;

  // The 12-bit pixel word is packed as {blue, green, red}, with 4 bits per colour.
  localparam int BLUE_LSB  = 8;
  localparam int GREEN_LSB = 4;
  localparam int RED_LSB   = 0;

  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
  } scan_ctl_t;

  localparam scan_ctl_t SCAN_CTL_RESET = '{act: 1'b0, hs: 1'b1, vs: 1'b1};

endpackage

// File: rtl/vga_scan_ctrl_delay_line.sv
// Parameterised N-stage shift register with a configurable reset value.
// A depth of 0 passes the input straight through.
module vga_scan_ctrl_delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  if (DEPTH == 0) begin : g_pass
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = i_clk ^ i_rst_n;
    assign o_q = i_d;
  end else begin : g_shift
    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        for (int i = 0; i < DEPTH; i++) r_stage[i] <= RESET_VAL;
      end else begin
        r_stage[0] <= i_d;
        for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
      end
    end

    assign o_q = r_stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_scan_ctrl.sv
// Generates the VGA raster counters and position outputs, then registers page pixels onto the pins.
// Syncs and the visible-area flag are delayed by the page latency so that they line up with the colour.
module vga_scan_ctrl
  import vga_scan_ctrl_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int PIX_LAT  = 1
) (
  input  logic             vga_clk,
  input  logic             vga_rst_n,
  input  logic [PIX_W-1:0] pixel_data,
  output logic [CNT_W-1:0] x_pos,
  output logic [CNT_W-1:0] y_pos,
  output logic             frame_start,
  output logic [3:0]       vga_r,
  output logic [3:0]       vga_g,
  output logic [3:0]       vga_b,
  output logic             hsync,
  output logic             vsync,
  output logic             den
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] C_H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] C_V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] C_H_ACTIVE   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] C_V_ACTIVE   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] C_HS_START   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] C_HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] C_VS_START   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] C_VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] r_v_cnt;
  logic             w_act;
  logic             w_fs;
  scan_ctl_t        w_ctl0;
  scan_ctl_t        r_ctl1;
  scan_ctl_t        w_ctl_d;
  logic [CNT_W-1:0] r_x_pos;
  logic [CNT_W-1:0] r_y_pos;
  logic             r_frame_start;
  logic [3:0]       r_vga_r;
  logic [3:0]       r_vga_g;
  logic [3:0]       r_vga_b;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_den;

  // The frame counter wraps on the same edge as the last line's horizontal wrap.
  always_ff @(posedge vga_clk or negedge vga_rst_n) begin
    if (!vga_rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == C_H_LAST) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == C_V_LAST) ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  always_comb begin
    w_act     = (r_h_cnt < C_H_ACTIVE) && (r_v_cnt < C_V_ACTIVE);
    w_fs      = (r_h_cnt == '0) && (r_v_cnt == '0);
    w_ctl0.act = w_act;
    w_ctl0.hs  = !((r_h_cnt >= C_HS_START) && (r_h_cnt <= C_HS_END));
    w_ctl0.vs  = !((r_v_cnt >= C_VS_START) && (r_v_cnt <= C_VS_END));
  end

  always_ff @(posedge vga_clk or negedge vga_rst_n) begin
    if (!vga_rst_n) begin
      r_x_pos       <= '0;
      r_y_pos       <= '0;
      r_frame_start <= 1'b0;
      r_ctl1        <= SCAN_CTL_RESET;
    end else begin
      r_x_pos       <= w_act ? r_h_cnt : '0;
      r_y_pos       <= w_act ? r_v_cnt : '0;
      r_frame_start <= w_fs;
      r_ctl1        <= w_ctl0;
    end
  end

  vga_scan_ctrl_delay_line #(
    .WIDTH     ($bits(scan_ctl_t)),
    .DEPTH     (PIX_LAT),
    .RESET_VAL (SCAN_CTL_RESET)
  ) u_ctl_delay (
    .i_clk   (vga_clk),
    .i_rst_n (vga_rst_n),
    .i_d     (r_ctl1),
    .o_q     (w_ctl_d)
  );

  // Colour is gated with the delayed active flag, so blanking is black whatever the page drives.
  always_ff @(posedge vga_clk or negedge vga_rst_n) begin
    if (!vga_rst_n) begin
      r_vga_r <= '0;
      r_vga_g <= '0;
      r_vga_b <= '0;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
      r_den   <= 1'b0;
    end else begin
      r_vga_b <= w_ctl_d.act ? pixel_data[BLUE_LSB  +: 4] : 4'h0;
      r_vga_g <= w_ctl_d.act ? pixel_data[GREEN_LSB +: 4] : 4'h0;
      r_vga_r <= w_ctl_d.act ? pixel_data[RED_LSB   +: 4] : 4'h0;
      r_hsync <= w_ctl_d.hs;
      r_vsync <= w_ctl_d.vs;
      r_den   <= w_ctl_d.act;
    end
  end

  assign x_pos       = r_x_pos;
  assign y_pos       = r_y_pos;
  assign frame_start = r_frame_start;
  assign vga_r       = r_vga_r;
  assign vga_g       = r_vga_g;
  assign vga_b       = r_vga_b;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign den         = r_den;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Scoreboard bench for vga_scan_ctrl on a shrunken raster, with page latencies of 1 and 3.
// Expected pin values are queued per presented position and popped as the pins should show them.
module tb_vga_scan_ctrl;

  localparam int TH_ACTIVE = 16;
  localparam int TH_FP     = 2;
  localparam int TH_SYNC   = 4;
  localparam int TH_BP     = 3;
  localparam int TV_ACTIVE = 8;
  localparam int TV_FP     = 2;
  localparam int TV_SYNC   = 2;
  localparam int TV_BP     = 3;
  localparam int TH_TOTAL  = TH_ACTIVE + TH_FP + TH_SYNC + TH_BP;
  localparam int TV_TOTAL  = TV_ACTIVE + TV_FP + TV_SYNC + TV_BP;
  localparam int TFRAME    = TH_TOTAL * TV_TOTAL;

  logic       clock    = 1'b0;
  logic       resetN   = 1'b0;
  logic [1:0] pageMode = 2'd0;
  int         compared   = 0;
  int         mismatched = 0;

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Pin tuple for raster position index c: {den, hsync, vsync, blue, green, red}.
  function automatic logic [14:0] expectPins(input int c, input logic [1:0] mode);
    int h, v;
    logic act, hs, vs;
    logic [11:0] rgb;
    h   = c % TH_TOTAL;
    v   = (c / TH_TOTAL) % TV_TOTAL;
    act = (h < TH_ACTIVE) && (v < TV_ACTIVE);
    hs  = !((h >= TH_ACTIVE + TH_FP) && (h < TH_ACTIVE + TH_FP + TH_SYNC));
    vs  = !((v >= TV_ACTIVE + TV_FP) && (v < TV_ACTIVE + TV_FP + TV_SYNC));
    case (mode)
      2'd0:    rgb = 12'(h);
      2'd1:    rgb = 12'hFFF;
      default: rgb = 12'hF00;
    endcase
    if (!act) rgb = 12'h000;
    return {act, hs, vs, rgb};
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int LAT = (gi == 0) ? 1 : 3;

    logic [11:0] pixelData;
    logic [9:0]  xPos, yPos;
    logic        frameStart;
    logic [3:0]  vgaR, vgaG, vgaB;
    logic        hsync, vsync, den;
    logic [9:0]  pageDly [LAT];
    int          edgeCnt;
    logic [14:0] pinQ [$];

    // Page model: returns data for x_pos after LAT clock edges.
    always @(posedge clock) begin
      pageDly[0] <= xPos;
      for (int i = 1; i < LAT; i++) pageDly[i] <= pageDly[i-1];
    end

    always_comb begin
      case (pageMode)
        2'd0:    pixelData = {2'b00, pageDly[LAT-1]};
        2'd1:    pixelData = 12'hFFF;
        default: pixelData = 12'hF00;
      endcase
    end

    vga_scan_ctrl #(
      .H_ACTIVE (TH_ACTIVE), .H_FP (TH_FP), .H_SYNC (TH_SYNC), .H_BP (TH_BP),
      .V_ACTIVE (TV_ACTIVE), .V_FP (TV_FP), .V_SYNC (TV_SYNC), .V_BP (TV_BP),
      .PIX_LAT  (LAT)
    ) dut (
      .vga_clk     (clock),
      .vga_rst_n   (resetN),
      .pixel_data  (pixelData),
      .x_pos       (xPos),
      .y_pos       (yPos),
      .frame_start (frameStart),
      .vga_r       (vgaR),
      .vga_g       (vgaG),
      .vga_b       (vgaB),
      .hsync       (hsync),
      .vsync       (vsync),
      .den         (den)
    );

    always @(posedge clock or negedge resetN) begin
      if (!resetN) edgeCnt <= 0;
      else         edgeCnt <= edgeCnt + 1;
    end

    task automatic checkResetState(input string where);
      checkOutput($sformatf("lat%0d %s x_pos", LAT, where), 32'(xPos), 32'd0);
      checkOutput($sformatf("lat%0d %s y_pos", LAT, where), 32'(yPos), 32'd0);
      checkOutput($sformatf("lat%0d %s frame_start", LAT, where), 32'(frameStart), 32'd0);
      checkOutput($sformatf("lat%0d %s pins", LAT, where),
                  32'({den, hsync, vsync, vgaB, vgaG, vgaR}), 32'({1'b0, 1'b1, 1'b1, 12'h000}));
    endtask

    // Outputs must reach reset values without waiting for a clock edge.
    always @(negedge resetN) begin
      #1;
      checkResetState("async");
    end

    always @(negedge clock) begin
      int          c1, h, v;
      logic        act;
      logic [14:0] expPins;
      if (!resetN || edgeCnt == 0) begin
        pinQ.delete();
        checkResetState("idle");
      end else begin
        c1  = edgeCnt - 1;
        h   = c1 % TH_TOTAL;
        v   = (c1 / TH_TOTAL) % TV_TOTAL;
        act = (h < TH_ACTIVE) && (v < TV_ACTIVE);
        checkOutput($sformatf("lat%0d x_pos", LAT), 32'(xPos), act ? 32'(h) : 32'd0);
        checkOutput($sformatf("lat%0d y_pos", LAT), 32'(yPos), act ? 32'(v) : 32'd0);
        checkOutput($sformatf("lat%0d frame_start", LAT), 32'(frameStart),
                    32'((h == 0) && (v == 0)));
        pinQ.push_back(expectPins(c1, pageMode));
        if (pinQ.size() > 1 + LAT) expPins = pinQ.pop_front();
        else                       expPins = {1'b0, 1'b1, 1'b1, 12'h000};
        checkOutput($sformatf("lat%0d den", LAT), 32'(den), 32'(expPins[14]));
        checkOutput($sformatf("lat%0d hsync", LAT), 32'(hsync), 32'(expPins[13]));
        checkOutput($sformatf("lat%0d vsync", LAT), 32'(vsync), 32'(expPins[12]));
        checkOutput($sformatf("lat%0d rgb", LAT), 32'({vgaB, vgaG, vgaR}), 32'(expPins[11:0]));
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] mode, input int runCycles);
    #2 resetN = 1'b0;
    pageMode = mode;
    repeat (2) @(posedge clock);
    #2 resetN = 1'b1;
    repeat (runCycles) @(posedge clock);
  endtask

  initial begin
    $display("[TB] starting vga_scan_ctrl bench");
    resetN   = 1'b0;
    pageMode = 2'd0;
    repeat (3) @(posedge clock);
    #2 resetN = 1'b1;
    repeat (2 * TFRAME + 20) @(posedge clock);

    applyStimulus(2'd1, TFRAME + 10);

    // Interrupt the frame at x=8, y=4, hold reset for 3 cycles, then restart from (0,0).
    applyStimulus(2'd2, 4 * TH_TOTAL + 8 + 1);
    #2 resetN = 1'b0;
    repeat (3) @(posedge clock);
    #2 resetN = 1'b1;
    repeat (TFRAME + 10) @(posedge clock);

    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
